// File: rtl/montexp_sequencer.sv
// montexp_sequencer
//   Drives a single montmult_triple_M instance through a left-to-right
//   square-and-multiply exponentiation: result = base^exponent. The base is
//   given in Montgomery form and a final multiply by 1 brings the result back
//   to the normal domain. The multiplier is owned exclusively by this block.
//
//   Build option: MONTEXP_SKIP_LEADING_ZEROS_EN
//     defined   - LOAD scans down from the MSB (one bit per cycle) and starts
//                 squaring at the highest set exponent bit.
//     undefined - always EXP_WIDTH squarings (constant-time operation count).
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   req              start request, honoured only in IDLE
//   base             base in Montgomery form
//   one_mont         R mod M for the selected modulus
//   exponent         exponent, processed MSB first
//   m_sel            modulus select, latched and forwarded as mm_M_select
//   busy             high while an operation is in progress
//   done             one-cycle completion pulse
//   result           final product (< 2M), held until the next completion
//   mm_start         one-cycle start pulse to the multiplier
//   mm_multiplier    multiplier operand (accumulator)
//   mm_multiplicand  multiplicand operand (acc, base or 1)
//   mm_M_select      latched modulus select
//   mm_done          multiplier done level
//   mm_product       multiplier product, valid while mm_done is high
module montexp_sequencer #(
  parameter int unsigned M_length  = 512,
  parameter int unsigned EXP_WIDTH = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req,
  input  logic [M_length+15:0]   base,
  input  logic [M_length+15:0]   one_mont,
  input  logic [EXP_WIDTH-1:0]   exponent,
  input  logic [1:0]             m_sel,
  output logic                   busy,
  output logic                   done,
  output logic [M_length+15:0]   result,
  output logic                   mm_start,
  output logic [M_length+15:0]   mm_multiplier,
  output logic [M_length+15:0]   mm_multiplicand,
  output logic [1:0]             mm_M_select,
  input  logic                   mm_done,
  input  logic [M_length+15:0]   mm_product
);

  localparam int unsigned W  = M_length + 16;
  localparam int unsigned IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_SQR_ISSUE,
    S_SQR_WAIT,
    S_MUL_ISSUE,
    S_MUL_WAIT,
    S_NEXT,
    S_CONV_ISSUE,
    S_CONV_WAIT,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [W-1:0]         r_base;
  logic [W-1:0]         r_acc;
  logic [W-1:0]         r_result;
  logic [EXP_WIDTH-1:0] r_exp;
  logic [1:0]           r_msel;
  logic [IW-1:0]        r_idx;
  logic                 r_wait_armed;
  logic                 w_mm_ack;
  logic                 w_bit;

  // The multiplier still shows the previous done level during the first wait
  // cycle; r_wait_armed is low exactly on the first cycle of any state, so
  // mm_done is only trusted from the second wait cycle onwards.
  assign w_mm_ack = r_wait_armed & mm_done;
  assign w_bit    = r_exp[r_idx];

  assign mm_multiplier = r_acc;
  assign mm_M_select   = r_msel;
  assign result        = r_result;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    mm_start        = 1'b0;
    mm_multiplicand = '0;
    busy            = 1'b1;
    done            = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (req) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (r_exp == '0) w_state_nxt = S_CONV_ISSUE;
`ifdef MONTEXP_SKIP_LEADING_ZEROS_EN
        else if (w_bit)  w_state_nxt = S_SQR_ISSUE;
`else
        else             w_state_nxt = S_SQR_ISSUE;
`endif
      end
      S_SQR_ISSUE: begin
        mm_start        = 1'b1;
        mm_multiplicand = r_acc;
        w_state_nxt     = S_SQR_WAIT;
      end
      S_SQR_WAIT: begin
        mm_multiplicand = r_acc;
        if (w_mm_ack) w_state_nxt = w_bit ? S_MUL_ISSUE : S_NEXT;
      end
      S_MUL_ISSUE: begin
        mm_start        = 1'b1;
        mm_multiplicand = r_base;
        w_state_nxt     = S_MUL_WAIT;
      end
      S_MUL_WAIT: begin
        mm_multiplicand = r_base;
        if (w_mm_ack) w_state_nxt = S_NEXT;
      end
      S_NEXT: begin
        w_state_nxt = (r_idx == '0) ? S_CONV_ISSUE : S_SQR_ISSUE;
      end
      S_CONV_ISSUE: begin
        mm_start        = 1'b1;
        mm_multiplicand = W'(1);
        w_state_nxt     = S_CONV_WAIT;
      end
      S_CONV_WAIT: begin
        mm_multiplicand = W'(1);
        if (w_mm_ack) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        busy        = 1'b0;
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base       <= '0;
      r_acc        <= '0;
      r_result     <= '0;
      r_exp        <= '0;
      r_msel       <= '0;
      r_idx        <= '0;
      r_wait_armed <= 1'b0;
    end else begin
      r_wait_armed <= (w_state_nxt == r_state);
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_base <= base;
            r_exp  <= exponent;
            r_msel <= m_sel;
            r_acc  <= one_mont;
            r_idx  <= IW'(EXP_WIDTH - 1);
          end
        end
`ifdef MONTEXP_SKIP_LEADING_ZEROS_EN
        // A set bit exists whenever the exponent is non-zero, so the scan
        // always stops before the index could wrap.
        S_LOAD: begin
          if ((r_exp != '0) && !w_bit) r_idx <= r_idx - IW'(1);
        end
`endif
        S_SQR_WAIT, S_MUL_WAIT: begin
          if (w_mm_ack) r_acc <= mm_product;
        end
        S_NEXT: begin
          if (r_idx != '0) r_idx <= r_idx - IW'(1);
        end
        S_CONV_WAIT: begin
          if (w_mm_ack) r_result <= mm_product;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_montexp_sequencer.sv
module tb_montexp_sequencer;

  localparam int ML     = 16;
  localparam int EW     = 32;
  localparam int W      = ML + 16;
  localparam int BUDGET = 6000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0;
  logic [W-1:0]  base = '0;
  logic [W-1:0]  one_mont = '0;
  logic [EW-1:0] exponent = '0;
  logic [1:0]    m_sel = '0;
  logic          busy, done, mm_start;
  logic [W-1:0]  result, mm_multiplier, mm_multiplicand;
  logic [1:0]    mm_M_select;
  logic          mm_done = 1'b1;
  logic [W-1:0]  mm_product = '0;

  int checks = 0;
  int errors = 0;

  logic [63:0] mods [4];
  logic [1:0]  exp_msel = '0;
  int start_count = 0, consec_viol = 0, msel_viol = 0, stab_viol = 0;

  montexp_sequencer #(.M_length(ML), .EXP_WIDTH(EW)) dut (
    .clk(clk), .rst(rst), .req(req), .base(base), .one_mont(one_mont),
    .exponent(exponent), .m_sel(m_sel), .busy(busy), .done(done),
    .result(result), .mm_start(mm_start), .mm_multiplier(mm_multiplier),
    .mm_multiplicand(mm_multiplicand), .mm_M_select(mm_M_select),
    .mm_done(mm_done), .mm_product(mm_product)
  );

  always #5 clk = ~clk;

  // Montgomery product a*b*2^-W mod m, bit-serial REDC
  function automatic logic [63:0] mont(input logic [63:0] a, input logic [63:0] b,
                                       input logic [63:0] m);
    logic [63:0] t;
    t = '0;
    for (int i = 0; i < W; i++) begin
      if (a[i]) t = t + b;
      if (t[0]) t = t + m;
      t = t >> 1;
    end
    return t;
  endfunction

  function automatic logic [63:0] powmod(input logic [63:0] x, input logic [31:0] e,
                                         input logic [63:0] m);
    logic [63:0] r, b;
    r = 64'd1 % m;
    b = x % m;
    for (int i = 0; i < 32; i++) begin
      if (e[i]) r = (r * b) % m;
      b = (b * b) % m;
    end
    return r;
  endfunction

  function automatic int exp_starts(input logic [31:0] e);
    int msb;
    if (e == 0) return 1;
    msb = 0;
    for (int i = 0; i < 32; i++) if (e[i]) msb = i;
`ifdef MONTEXP_SKIP_LEADING_ZEROS_EN
    return msb + 1 + $countones(e) + 1;
`else
    return EW + $countones(e) + 1;
`endif
  endfunction

  // Multiplier stand-in: done stays high (stale) through the first wait cycle,
  // drops, then returns high with the product after a random latency.
  int          age = 0, lat = 0;
  bit          mm_busy = 0, chk = 0, prev_start = 0;
  logic [63:0] pend;
  logic [W-1:0] snap_a, snap_b;

  always @(negedge clk) begin
    if (rst) chk = 0;
    if (mm_start) begin
      if (prev_start) consec_viol++;
      if (mm_M_select !== exp_msel) msel_viol++;
      start_count++;
      pend    = mont(64'(mm_multiplier), 64'(mm_multiplicand), mods[mm_M_select]);
      snap_a  = mm_multiplier;
      snap_b  = mm_multiplicand;
      age     = 0;
      lat     = $urandom_range(1, 5);
      mm_busy = 1;
      chk     = 1;
    end else if (mm_busy) begin
      age++;
      if (chk && (mm_multiplier !== snap_a || mm_multiplicand !== snap_b ||
                  mm_M_select !== exp_msel)) stab_viol++;
      if (age == 2) mm_done = 1'b0;
      if (age == 2 + lat) begin
        mm_done    = 1'b1;
        mm_product = W'(pend);
        mm_busy    = 0;
        chk        = 0;
      end
    end
    prev_start = mm_start;
  end

  task automatic apply_inputs(input logic [63:0] x, input logic [31:0] e, input logic [1:0] ms);
    logic [63:0] m;
    m        = mods[ms];
    base     = W'(((x % m) << 32) % m);
    one_mont = W'((64'd1 << 32) % m);
    exponent = e;
    m_sel    = ms;
    exp_msel = ms;
  endtask

  task automatic do_op(input logic [63:0] x, input logic [31:0] e, input logic [1:0] ms,
                       input bit poke, output logic [W-1:0] res, output int pulses,
                       output int starts, output bit tmo, output int busy_after,
                       output logic busy_first);
    int s0;
    @(negedge clk);
    apply_inputs(x, e, ms);
    req = 1'b1;
    s0  = start_count;
    @(negedge clk);
    req        = 1'b0;
    busy_first = busy;
    base       = $urandom;
    one_mont   = $urandom;
    exponent   = $urandom;
    m_sel      = 2'($urandom_range(0, 2));
    tmo = 1; pulses = 0; busy_after = 0; res = '0;
    for (int cyc = 0; cyc < BUDGET; cyc++) begin
      req = poke && (cyc == 4);
      if (done) begin
        res = result; pulses = 1; tmo = 0;
        req = poke;
        break;
      end
      @(negedge clk);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req = 1'b0;
      if (done) pulses++;
      if (busy) busy_after++;
    end
    starts = start_count - s0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
    checks++; if (result !== '0) begin errors++; $display("FAIL reset_result got %0h want 0", result); end
    checks++; if (mm_start !== 1'b0) begin errors++; $display("FAIL reset_mm_start got %0b want 0", mm_start); end
    checks++; if (mm_M_select !== 2'b00) begin errors++; $display("FAIL reset_msel got %0b want 00", mm_M_select); end
    checks++; if (mm_multiplier !== '0 || mm_multiplicand !== '0) begin
      errors++; $display("FAIL reset_operands got %0h/%0h want 0/0", mm_multiplier, mm_multiplicand); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %0b want 0", busy); end
  endtask

  task automatic test_exp_zero();
    logic [W-1:0] res; int p, s, ba; bit tmo; logic bf;
    do_op(64'($urandom_range(0, 32'(mods[2] - 1))), 32'd0, 2'b10, 0, res, p, s, tmo, ba, bf);
    checks++; if (tmo) begin errors++; $display("FAIL exp0_timeout got no done want done"); end
    checks++; if (res !== W'(1)) begin errors++; $display("FAIL exp0_result got %0h want 1", res); end
    checks++; if (s != 1) begin errors++; $display("FAIL exp0_starts got %0d want 1", s); end
    checks++; if (p != 1) begin errors++; $display("FAIL exp0_pulses got %0d want 1", p); end
    checks++; if (bf !== 1'b1) begin errors++; $display("FAIL exp0_busy_first got %0b want 1", bf); end
    checks++; if (result !== res) begin errors++; $display("FAIL exp0_hold got %0h want %0h", result, res); end
  endtask

  task automatic check_run(input string name, input logic [63:0] x, input logic [31:0] e,
                           input logic [1:0] ms, input bit poke);
    logic [W-1:0] res; int p, s, ba; bit tmo; logic bf; logic [63:0] m, want;
    m    = mods[ms];
    want = powmod(x, e, m);
    do_op(x, e, ms, poke, res, p, s, tmo, ba, bf);
    checks++; if (tmo) begin errors++; $display("FAIL %s_timeout got no done want done", name); end
    checks++; if ((64'(res) % m) != want || 64'(res) >= 2 * m) begin
      errors++; $display("FAIL %s_result got %0h want %0h mod %0h", name, res, want, m); end
    checks++; if (s != exp_starts(e)) begin
      errors++; $display("FAIL %s_starts got %0d want %0d", name, s, exp_starts(e)); end
    checks++; if (p != 1) begin errors++; $display("FAIL %s_pulses got %0d want 1", name, p); end
    checks++; if (ba != 0) begin errors++; $display("FAIL %s_busy_after got %0d want 0", name, ba); end
    checks++; if (result !== res) begin errors++; $display("FAIL %s_hold got %0h want %0h", name, result, res); end
  endtask

  task automatic test_exp_one();
    check_run("exp1", 64'd5, 32'd1, 2'b10, 0);
  endtask

  task automatic test_f4();
    check_run("f4", 64'd5, 32'h0001_0001, 2'b10, 0);
  endtask

  task automatic test_random();
    logic [31:0] e; logic [1:0] ms;
    for (int n = 0; n < 5; n++) begin
      ms = 2'($urandom_range(0, 2));
      e  = $urandom >> $urandom_range(0, 31);
      check_run("rand", 64'($urandom_range(0, 32'(mods[ms] - 1))), e, ms, 0);
    end
  endtask

  task automatic test_req_ignored();
    check_run("req_ignored", 64'($urandom_range(0, 32'(mods[2] - 1))),
              32'($urandom_range(1, 65535)), 2'b10, 1);
  endtask

  task automatic test_reset_mid();
    int s0; bit reached;
    @(negedge clk);
    apply_inputs(64'd7, 32'hFFFF_FFFF, 2'b00);
    req = 1'b1;
    s0  = start_count;
    @(negedge clk);
    req = 1'b0;
    reached = 0;
    for (int cyc = 0; cyc < BUDGET; cyc++) begin
      if (start_count - s0 >= 2) begin reached = 1; break; end
      @(negedge clk);
    end
    checks++; if (!reached) begin errors++; $display("FAIL rstmid_reach got no mul want mul"); end
    @(negedge clk); @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before got %0b want 1", busy); end
    rst = 1'b1;
    #1;
    checks++; if (mm_start !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL rstmid_idle got start=%0b busy=%0b done=%0b want 0/0/0", mm_start, busy, done); end
    @(negedge clk);
    rst = 1'b0;
    check_run("after_rst", 64'd2, 32'd3, 2'b00, 0);
  endtask

  task automatic test_msel01();
    check_run("msel01", 64'($urandom_range(0, 32'(mods[1] - 1))), $urandom, 2'b01, 0);
    checks++; if (msel_viol != 0) begin errors++; $display("FAIL msel_track got %0d want 0", msel_viol); end
    checks++; if (stab_viol != 0) begin errors++; $display("FAIL operand_stable got %0d want 0", stab_viol); end
    checks++; if (consec_viol != 0) begin errors++; $display("FAIL start_consec got %0d want 0", consec_viol); end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) mods[k] = 64'($urandom_range(32768, 65535)) | 64'd1;
    mods[3] = mods[0];
    test_reset();
    test_exp_zero();
    test_exp_one();
    test_f4();
    test_random();
    test_req_ignored();
    test_reset_mid();
    test_msel01();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
